log_reader: RTL and testbench
=============================

Name: log_reader

Overview:
- Drain-side companion to the event logger that writes 37-bit records ({opcode[2:0], pc[15:0], addr[15:0], en, wr}) into the dual-port log RAM.
- Tracks the logger's write stream and reads records back through the RAM's synchronous read port.
- Decodes each record into typed fields and presents it to a host/attestation consumer over a valid/ready handshake.
- Detects ring overrun and malformed records.

Parameters:
ADDR_W, 16, log RAM address width; ring depth = 2^ADDR_W entries; logger wraps at all-ones.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
log_we  input  1  logger's registered write strobe; one record committed per cycle high
log_clr  input  1  same signal as the logger's clr_ram; synchronous log clear
rd_enable  input  1  permits new RAM reads when high
ram_rd_en  output  1  RAM read strobe
ram_rd_addr  output  ADDR_W  RAM read address
ram_rd_data  input  37  RAM read data, valid the cycle after ram_rd_en
evt_valid  output  1  decoded record available
evt_ready  input  1  consumer accepts record
evt_opcode  output  3  record opcode (1,2,3,4,5,7 valid)
evt_pc  output  16  record pc field [33:18]
evt_addr  output  16  record address field [17:2]
evt_en  output  1  record bit 1
evt_wr  output  1  record bit 0
evt_seq  output  ADDR_W  RAM address the record came from
empty  output  1  count == 0
overflow  output  1  sticky: at least one record lost to overrun
lost_cnt  output  16  saturating count of overrun-lost records
bad_cnt  output  16  saturating count of dropped malformed records

Behaviour:
- Reset (async): FSM=IDLE, rd_ptr=0, count=0. All outputs 0 except empty=1.
- count: ADDR_W+1 bits.
  - +1 on log_we; -1 on read issue; net 0 when both occur in the same cycle.
- FSM IDLE:
  - If rd_enable && count!=0: assert ram_rd_en=1 with ram_rd_addr=rd_ptr for one cycle.
  - Then rd_ptr <= rd_ptr+1 (mod 2^ADDR_W, FFFF->0), go to WAIT.
- FSM WAIT: capture ram_rd_data.
  - Opcode in {000,110}: drop the record, bad_cnt++ (saturating at FFFF), go to IDLE.
  - Otherwise: load the evt_* registers, set evt_seq = issued address, go to PRESENT.
- FSM PRESENT:
  - evt_valid=1; all evt_* held stable until evt_ready.
  - On evt_valid&&evt_ready: evt_valid <= 0 next cycle, go to IDLE.
  - Throughput: 1 record per 3 cycles minimum.
- Latency: log_we at cycle t into an empty log -> ram_rd_en at t+1 -> evt_valid at t+3.
  - No read is ever issued to an address in the same cycle it is written.
- Overrun: log_we while count==2^ADDR_W and no issue that cycle.
  - count unchanged; rd_ptr <= rd_ptr+1 (oldest record lost).
  - lost_cnt++ (saturating at FFFF); overflow <= 1.
  - If a read issues in the same cycle: no loss.
- rd_enable low: no new issue. A read already in WAIT/PRESENT completes normally.
- log_clr (synchronous, highest priority after reset):
  - rd_ptr=0, count=0, FSM=IDLE, evt_valid=0; overflow, lost_cnt, bad_cnt cleared.
  - log_we in the same cycle is ignored (count stays 0).
  - An in-flight record in WAIT or PRESENT is discarded without handshake.
- evt_* outputs are registered; ram_rd_en and ram_rd_addr are registered FSM outputs.
- empty reflects count only; a record in WAIT or PRESENT does not count.

Test Plan:
1. Single record:
   - Stimulus: log_we at t with RAM[0]={001,16'h1234,16'h0200,1,0}.
   - Required: ram_rd_en/addr=0 at t+1; evt_valid at t+3 with opcode=1, pc=1234, addr=0200, en=1, wr=0, seq=0; empty=1 after issue.
2. Backpressure:
   - Stimulus: 3 records written, evt_ready low 10 cycles then high.
   - Required: first record held stable throughout; records then delivered in order seq=0,1,2; no extra RAM reads while in PRESENT.
3. Malformed records:
   - Stimulus: RAM[0] opcode=000, RAM[1] opcode=110, RAM[2] opcode=010.
   - Required: bad_cnt=2; only seq=2 is presented.
4. Wrap and overrun (ADDR_W=4):
   - Stimulus: rd_enable=0, 18 log_we pulses.
   - Required: count=16, lost_cnt=2, overflow=1. After rd_enable=1, first seq=2, then ... F,0,1 with wrap; 16 events total.
5. Clear mid-operation:
   - Stimulus: log_clr asserted while in PRESENT with 5 pending, simultaneous log_we.
   - Required: evt_valid=0 next cycle, empty=1, counters=0; next log_we reads address 0.
6. Async reset mid-WAIT:
   - Stimulus: assert reset between clock edges.
   - Required: outputs zero immediately (empty=1); no evt_valid after release until a new log_we.

Source files
------------

// File: rtl/log_reader.sv
// Drain side of the event log: follows the logger's write stream, reads each record back
// through the RAM's synchronous port, drops malformed ones and hands the rest to a valid/ready consumer.
module log_reader #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              log_we,
  input  logic              log_clr,
  input  logic              rd_enable,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [36:0]       ram_rd_data,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [2:0]        evt_opcode,
  output logic [15:0]       evt_pc,
  output logic [15:0]       evt_addr,
  output logic              evt_en,
  output logic              evt_wr,
  output logic [ADDR_W-1:0] evt_seq,
  output logic              empty,
  output logic              overflow,
  output logic [15:0]       lost_cnt,
  output logic [15:0]       bad_cnt
);

  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, READ, WAIT, PRESENT} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              issue, overrun, bad_op, accept, have_rec;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // A record written this very cycle is readable from the next cycle on, so it
  // already justifies an issue; this is what gives the t+1 read strobe.
  always_comb begin
    accept    = evt_valid && evt_ready;
    bad_op    = (ram_rd_data[36:34] == 3'b000) || (ram_rd_data[36:34] == 3'b110);
    have_rec  = rd_enable && ((count != '0) || log_we);
    issue     = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        if (have_rec) begin
          issue     = 1'b1;
          state_nxt = READ;
        end
      end
      READ:    state_nxt = WAIT;
      WAIT:    state_nxt = bad_op ? IDLE : PRESENT;
      PRESENT: begin
        if (accept) begin
          state_nxt = IDLE;
          if (have_rec) begin
            issue     = 1'b1;
            state_nxt = READ;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (log_clr) begin
      issue     = 1'b0;
      state_nxt = IDLE;
    end
    overrun = log_we && !log_clr && (count == FULL) && !issue;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  assign empty = (count == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr      <= '0;
      count       <= '0;
      ram_rd_en   <= 1'b0;
      ram_rd_addr <= '0;
      evt_valid   <= 1'b0;
      evt_opcode  <= '0;
      evt_pc      <= '0;
      evt_addr    <= '0;
      evt_en      <= 1'b0;
      evt_wr      <= 1'b0;
      evt_seq     <= '0;
      overflow    <= 1'b0;
      lost_cnt    <= '0;
      bad_cnt     <= '0;
    end else if (log_clr) begin
      rd_ptr      <= '0;
      count       <= '0;
      ram_rd_en   <= 1'b0;
      ram_rd_addr <= '0;
      evt_valid   <= 1'b0;
      overflow    <= 1'b0;
      lost_cnt    <= '0;
      bad_cnt     <= '0;
    end else begin
      ram_rd_en <= issue;
      if (issue) ram_rd_addr <= rd_ptr;
      // Overrun drops the oldest record by stepping the read pointer past it.
      if (issue || overrun) rd_ptr <= rd_ptr + 1'b1;
      if (issue && !log_we)                  count <= count - 1'b1;
      else if (log_we && !issue && !overrun) count <= count + 1'b1;
      if (overrun) begin
        lost_cnt <= sat_inc(lost_cnt);
        overflow <= 1'b1;
      end
      // WAIT boundary: RAM data is valid now, decode or drop it
      if (state == WAIT) begin
        if (bad_op) begin
          bad_cnt <= sat_inc(bad_cnt);
        end else begin
          evt_opcode <= ram_rd_data[36:34];
          evt_pc     <= ram_rd_data[33:18];
          evt_addr   <= ram_rd_data[17:2];
          evt_en     <= ram_rd_data[1];
          evt_wr     <= ram_rd_data[0];
          evt_seq    <= ram_rd_addr;
          evt_valid  <= 1'b1;
        end
      end else if (accept) begin
        evt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_log_reader.sv
// Directed bench for log_reader with a 16-entry log RAM model and hand-computed
// expected records, pointers and counters.
module tb_log_reader;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset, log_we, log_clr, rd_enable, evt_ready;
  logic          ram_rd_en;
  logic [AW-1:0] ram_rd_addr;
  logic [36:0]   ram_rd_data;
  logic          evt_valid, evt_en, evt_wr, empty, overflow;
  logic [2:0]    evt_opcode;
  logic [15:0]   evt_pc, evt_addr, lost_cnt, bad_cnt;
  logic [AW-1:0] evt_seq;

  logic [36:0]   mem [0:15];
  logic [AW-1:0] wr_ptr;
  int            n_assert = 0;
  int            n_fail   = 0;

  log_reader #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .log_we(log_we), .log_clr(log_clr), .rd_enable(rd_enable),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_opcode(evt_opcode),
    .evt_pc(evt_pc), .evt_addr(evt_addr), .evt_en(evt_en), .evt_wr(evt_wr),
    .evt_seq(evt_seq), .empty(empty), .overflow(overflow), .lost_cnt(lost_cnt),
    .bad_cnt(bad_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [36:0] mk(input logic [2:0] op, input logic [15:0] pc,
                                     input logic [15:0] ad, input logic en, input logic wr);
    return {op, pc, ad, en, wr};
  endfunction

  task automatic write_rec(input logic [36:0] rec);
    mem[wr_ptr] = rec;
    log_we = 1'b1;
    @(negedge clk);
    log_we = 1'b0;
    wr_ptr = wr_ptr + 1'b1;
  endtask

  task automatic clear_log();
    log_clr = 1'b1;
    @(negedge clk);
    log_clr = 1'b0;
    wr_ptr = '0;
  endtask

  // Waits (bounded) for a presented record, checks it, then steps one cycle so
  // a ready consumer has taken it.
  task automatic expect_evt(input string tag, input int seq, input int pc, input int op);
    int n = 0;
    while (!evt_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!evt_valid) begin
      check_eq({tag, "_timeout"}, 64'd0, 64'd1);
    end else begin
      check_eq({tag, "_seq"}, 64'(evt_seq), 64'(seq));
      check_eq({tag, "_pc"}, 64'(evt_pc), 64'(pc));
      check_eq({tag, "_op"}, 64'(evt_opcode), 64'(op));
    end
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] snap;
    bit          stable;
    int          extra_rd;
    int          n;

    reset = 1'b1; log_we = 1'b0; log_clr = 1'b0; rd_enable = 1'b0; evt_ready = 1'b0;
    wr_ptr = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_valid", 64'(evt_valid), 64'd0);
    check_eq("rst_empty", 64'(empty), 64'd1);
    check_eq("rst_rd_en", 64'(ram_rd_en), 64'd0);
    check_eq("rst_cnts", {lost_cnt, bad_cnt, 15'd0, overflow}, 64'd0);
    reset = 1'b0;
    rd_enable = 1'b1;
    @(negedge clk);

    // 1: single record latency and decode
    write_rec(mk(3'd1, 16'h1234, 16'h0200, 1'b1, 1'b0));
    check_eq("t1_rd_en", 64'(ram_rd_en), 64'd1);
    check_eq("t1_rd_addr", 64'(ram_rd_addr), 64'd0);
    check_eq("t1_empty", 64'(empty), 64'd1);
    @(negedge clk);
    check_eq("t1_valid_t2", 64'(evt_valid), 64'd0);
    @(negedge clk);
    check_eq("t1_valid_t3", 64'(evt_valid), 64'd1);
    check_eq("t1_fields", {evt_opcode, evt_pc, evt_addr, evt_en, evt_wr, evt_seq},
             {3'd1, 16'h1234, 16'h0200, 1'b1, 1'b0, 4'd0});
    evt_ready = 1'b1;
    @(negedge clk);
    check_eq("t1_valid_drop", 64'(evt_valid), 64'd0);
    evt_ready = 1'b0;

    // 2: backpressure, order preserved, no reads while presenting
    clear_log();
    for (int i = 0; i < 3; i++) write_rec(mk(3'd2, 16'hA000 + 16'(i), 16'h0010, 1'b0, 1'b1));
    n = 0;
    while (!evt_valid && n < 20) begin @(negedge clk); n++; end
    check_eq("t2_first_valid", 64'(evt_valid), 64'd1);
    snap = {evt_opcode, evt_pc, evt_addr, evt_en, evt_wr, evt_seq};
    stable = 1'b1;
    extra_rd = 0;
    repeat (10) begin
      @(negedge clk);
      if ({evt_opcode, evt_pc, evt_addr, evt_en, evt_wr, evt_seq} !== snap || !evt_valid)
        stable = 1'b0;
      if (ram_rd_en) extra_rd++;
    end
    check_eq("t2_stable", 64'(stable), 64'd1);
    check_eq("t2_no_reads", 64'(extra_rd), 64'd0);
    evt_ready = 1'b1;
    for (int i = 0; i < 3; i++) expect_evt($sformatf("t2_e%0d", i), i, 'hA000 + i, 2);
    check_eq("t2_empty", 64'(empty), 64'd1);

    // 3: malformed records dropped
    clear_log();
    write_rec(mk(3'd0, 16'h1111, 16'h0, 1'b0, 1'b0));
    write_rec(mk(3'd6, 16'h2222, 16'h0, 1'b0, 1'b0));
    write_rec(mk(3'd2, 16'hBEEF, 16'h0, 1'b0, 1'b0));
    expect_evt("t3_e", 2, 'hBEEF, 2);
    repeat (4) @(negedge clk);
    check_eq("t3_bad_cnt", 64'(bad_cnt), 64'd2);
    check_eq("t3_idle", 64'(evt_valid), 64'd0);

    // 4: wrap and overrun with reads disabled
    clear_log();
    check_eq("t4_bad_clr", 64'(bad_cnt), 64'd0);
    rd_enable = 1'b0;
    for (int i = 0; i < 18; i++) write_rec(mk(3'd3, 16'h4000 + 16'(i), 16'h0, 1'b1, 1'b1));
    @(negedge clk);
    check_eq("t4_lost", 64'(lost_cnt), 64'd2);
    check_eq("t4_overflow", 64'(overflow), 64'd1);
    check_eq("t4_not_empty", 64'(empty), 64'd0);
    check_eq("t4_no_evt", 64'(evt_valid | ram_rd_en), 64'd0);
    rd_enable = 1'b1;
    for (int k = 0; k < 16; k++) expect_evt($sformatf("t4_e%0d", k), (k + 2) % 16, 'h4002 + k, 3);
    check_eq("t4_empty", 64'(empty), 64'd1);
    repeat (6) @(negedge clk);
    check_eq("t4_no_17th", 64'(evt_valid), 64'd0);

    // 5: clear while presenting with 5 pending and a simultaneous write
    evt_ready = 1'b0;
    for (int i = 0; i < 6; i++) write_rec(mk(3'd4, 16'h5000 + 16'(i), 16'h0, 1'b0, 1'b0));
    n = 0;
    while (!evt_valid && n < 20) begin @(negedge clk); n++; end
    check_eq("t5_present", 64'(evt_valid), 64'd1);
    check_eq("t5_seq", 64'(evt_seq), 64'd2);
    log_clr = 1'b1;
    log_we = 1'b1;
    @(negedge clk);
    log_clr = 1'b0;
    log_we = 1'b0;
    wr_ptr = '0;
    check_eq("t5_valid", 64'(evt_valid), 64'd0);
    check_eq("t5_empty", 64'(empty), 64'd1);
    check_eq("t5_cnts", {lost_cnt, bad_cnt, 15'd0, overflow}, 64'd0);
    repeat (3) @(negedge clk);
    check_eq("t5_quiet", 64'(evt_valid | ram_rd_en), 64'd0);
    write_rec(mk(3'd5, 16'h5555, 16'h0, 1'b0, 1'b0));
    check_eq("t5_rd_addr", {ram_rd_en, ram_rd_addr}, {1'b1, 4'd0});
    expect_evt("t5_e", 0, 'h5555, 5);

    // 6: async reset mid-WAIT
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
    write_rec(mk(3'd7, 16'h6666, 16'h0, 1'b0, 1'b0));
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_eq("t6_rst_out", {evt_valid, ram_rd_en, empty, overflow, evt_pc, ram_rd_addr},
             {1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 4'd0});
    @(negedge clk);
    reset = 1'b0;
    wr_ptr = '0;
    stable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (evt_valid || ram_rd_en) stable = 1'b0;
    end
    check_eq("t6_no_evt", 64'(stable), 64'd1);
    evt_ready = 1'b1;
    write_rec(mk(3'd7, 16'h7777, 16'h0, 1'b1, 1'b0));
    expect_evt("t6_e", 0, 'h7777, 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
